// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencer for an NxN matrix multiply, one C element at a time.
// Per element it issues N paired A/B reads, then drains the memory pipe and writes C.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               begin a full multiply; sampled only in IDLE
//   hold                stall read issue; honoured only in LOAD
//   busy, done          busy outside IDLE; one-cycle done pulse after the last C write
//   rd_en, addr_a/b     A (column-major) and B (row-major) read strobe and addresses
//   mac_en, mac_clr     MAC accumulate / load-first-term strobes, aligned to read latency
//   c_we, addr_c        C (row-major) write strobe and address
module matmul_seq_ctrl #(
    parameter int N       = 8,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              c_we,
    output logic [ADDR_W-1:0] addr_c
);

    localparam int                CW   = $clog2(N);
    localparam logic [CW-1:0]     LAST = CW'(N - 1);
    localparam logic [ADDR_W-1:0] NA   = ADDR_W'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;

    logic [MEM_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [MEM_LAT-1:0] clr_pipe_q, clr_pipe_d;
    logic [MEM_LAT-1:0] pend;
    logic [MEM_LAT-1:0] clr_sh;

    // Reads still in flight, excluding the one reaching the MAC this cycle.
    assign pend   = rd_pipe_q << 1;
    assign clr_sh = clr_pipe_q << 1;

    assign mac_en  = rd_pipe_q[MEM_LAT-1];
    assign mac_clr = clr_pipe_q[MEM_LAT-1];

    assign addr_a = ADDR_W'(k_q) * NA + ADDR_W'(i_q);
    assign addr_b = ADDR_W'(k_q) * NA + ADDR_W'(j_q);
    assign addr_c = ADDR_W'(i_q) * NA + ADDR_W'(j_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            rd_pipe_q  <= '0;
            clr_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            rd_pipe_q  <= rd_pipe_d;
            clr_pipe_q <= clr_pipe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        rd_en   = 1'b0;
        c_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_LOAD: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (k_q == LAST) begin
                        k_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Leave once only the final beat remains; it hits the MAC now.
                if (pend == '0) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                c_we = 1'b1;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + CW'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    j_d     = j_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_pipe_d  = pend | MEM_LAT'(rd_en);
        clr_pipe_d = clr_sh | MEM_LAT'(rd_en && (k_q == '0));
    end

endmodule
